// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Purpose  : Shared state encoding and helpers for the button conditioner.
//  Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

   localparam logic [2:0] c_IDLE         = 3'd0;
   localparam logic [2:0] c_PRESS_WAIT   = 3'd1;
   localparam logic [2:0] c_HELD         = 3'd2;
   localparam logic [2:0] c_REPEAT       = 3'd3;
   localparam logic [2:0] c_RELEASE_WAIT = 3'd4;

   typedef enum logic [2:0] {
      IDLE         = c_IDLE,
      PRESS_WAIT   = c_PRESS_WAIT,
      HELD         = c_HELD,
      REPEAT       = c_REPEAT,
      RELEASE_WAIT = c_RELEASE_WAIT
   } state_t;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser for an asynchronous level input.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= RESET_VALUE;
         r_sync <= RESET_VALUE;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Debounces a raw key into press/release/step strobes with
//             optional hold-to-repeat.
//  Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
   parameter int REPEAT_PERIOD_CYCLES = 5_000_000,
   parameter int ACTIVE_LOW           = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic button_in,
   input  logic repeat_en,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic step_pulse
);

   localparam int c_MAX   = maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
   localparam int c_CNT_W = $clog2(c_MAX) + 1;

   localparam logic               c_IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_DEB_LAST   = c_CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_DLY_LAST   = c_CNT_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_PER_LAST   = c_CNT_W'(REPEAT_PERIOD_CYCLES - 1);

   logic               w_keySync;
   logic               w_act;
   state_t             r_state;
   state_t             w_stateNext;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cntNext;
   logic               w_pressEv;
   logic               w_releaseEv;
   logic               w_repeatEv;
   logic               r_pressed;
   logic               r_pressPulse;
   logic               r_releasePulse;
   logic               r_stepPulse;

   sync_2ff #(
      .RESET_VALUE (c_IDLE_LEVEL)
   ) u_keySync (
      .clk     (clk),
      .reset   (reset),
      .i_async (button_in),
      .o_sync  (w_keySync)
   );

   assign w_act = w_keySync ^ c_IDLE_LEVEL;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
      end
   end

   // Release is tested first in HELD/REPEAT so it wins over a coincident strobe.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_pressEv   = 1'b0;
      w_releaseEv = 1'b0;
      w_repeatEv  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_act) begin
               w_stateNext = PRESS_WAIT;
               w_cntNext   = c_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!w_act) begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
               w_stateNext = HELD;
               w_cntNext   = '0;
               w_pressEv   = 1'b1;
            end else begin
               w_cntNext   = r_cnt + c_ONE;
            end
         end
         HELD: begin
            if (!w_act) begin
               w_stateNext = RELEASE_WAIT;
               w_cntNext   = c_ONE;
            end else if (repeat_en && (r_cnt == c_DLY_LAST)) begin
               w_stateNext = REPEAT;
               w_cntNext   = '0;
               w_repeatEv  = 1'b1;
            end else if (r_cnt != c_DLY_LAST) begin
               w_cntNext   = r_cnt + c_ONE;
            end
         end
         REPEAT: begin
            if (!w_act) begin
               w_stateNext = RELEASE_WAIT;
               w_cntNext   = c_ONE;
            end else if (!repeat_en) begin
               w_stateNext = HELD;
               w_cntNext   = '0;
            end else if (r_cnt == c_PER_LAST) begin
               w_cntNext   = '0;
               w_repeatEv  = 1'b1;
            end else begin
               w_cntNext   = r_cnt + c_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (w_act) begin
               w_stateNext = HELD;
               w_cntNext   = '0;
            end else if (r_cnt == c_DEB_LAST) begin
               w_stateNext = IDLE;
               w_cntNext   = '0;
               w_releaseEv = 1'b1;
            end else begin
               w_cntNext   = r_cnt + c_ONE;
            end
         end
         default: begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pressed      <= 1'b0;
         r_pressPulse   <= 1'b0;
         r_releasePulse <= 1'b0;
         r_stepPulse    <= 1'b0;
      end else begin
         r_pressed      <= (w_stateNext == HELD) || (w_stateNext == REPEAT) ||
                           (w_stateNext == RELEASE_WAIT);
         r_pressPulse   <= w_pressEv;
         r_releasePulse <= w_releaseEv;
         r_stepPulse    <= w_pressEv | w_repeatEv;
      end
   end

   assign pressed       = r_pressed;
   assign press_pulse   = r_pressPulse;
   assign release_pulse = r_releasePulse;
   assign step_pulse    = r_stepPulse;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Scoreboard bench for button_conditioner (debounce 4, delay 10,
//             period 3, active-low key).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

   typedef struct {
      int   at;
      logic p;
      logic r;
      logic s;
      logic pr;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   logic button_in;
   logic repeat_en;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic step_pulse;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   ev_t  q[$];
   ev_t  m_e;

   button_conditioner #(
      .DEBOUNCE_CYCLES      (4),
      .REPEAT_DELAY_CYCLES  (10),
      .REPEAT_PERIOD_CYCLES (3),
      .ACTIVE_LOW           (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .button_in     (button_in),
      .repeat_en     (repeat_en),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .step_pulse    (step_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe seen must match the oldest expected event.
   always @(negedge clk) begin
      if (press_pulse || release_pulse || step_pulse) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse cycle=%0d got press=%b release=%b step=%b, required no pulse",
                     cyc, press_pulse, release_pulse, step_pulse);
         end else begin
            m_e = q.pop_front();
            if (cyc != m_e.at || press_pulse !== m_e.p || release_pulse !== m_e.r ||
                step_pulse !== m_e.s || pressed !== m_e.pr) begin
               bad++;
               $display("FAIL pulse_event got cycle=%0d press=%b release=%b step=%b pressed=%b, required cycle=%0d press=%b release=%b step=%b pressed=%b",
                        cyc, press_pulse, release_pulse, step_pulse, pressed,
                        m_e.at, m_e.p, m_e.r, m_e.s, m_e.pr);
            end
         end
      end
   end

   function automatic void push(input int at, input logic p, input logic r,
                                input logic s, input logic pr);
      ev_t e;
      e.at = at; e.p = p; e.r = r; e.s = s; e.pr = pr;
      q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic got, input logic req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%b required=%b", name, got, req);
      end
   endtask

   task automatic chkOutsLow(input string name);
      chk({name, "_pressed"}, pressed, 1'b0);
      chk({name, "_press"},   press_pulse, 1'b0);
      chk({name, "_release"}, release_pulse, 1'b0);
      chk({name, "_step"},    step_pulse, 1'b0);
   endtask

   task automatic waitN(input int n);
      repeat (n) @(negedge clk);
   endtask

   int base;

   initial begin
      reset     = 1'b1;
      button_in = 1'b1;
      repeat_en = 1'b0;
      #1 reset = 1'b0;
      #1 chkOutsLow("reset");
      waitN(3);
      reset = 1'b1;
      waitN(5);

      // clean press and release
      @(negedge clk); button_in = 1'b0; push(cyc + 6, 1, 0, 1, 1);
      waitN(12);
      chk("clean_pressed_high", pressed, 1'b1);
      @(negedge clk); button_in = 1'b1; push(cyc + 6, 0, 1, 0, 0);
      waitN(10);
      chk("clean_pressed_low", pressed, 1'b0);

      // bounce: three 3-cycle lows separated by 1-cycle highs
      for (int k = 0; k < 3; k++) begin
         repeat (3) begin @(negedge clk); button_in = 1'b0; end
         @(negedge clk); button_in = 1'b1;
      end
      chk("bounce_pressed_low", pressed, 1'b0);
      @(negedge clk); button_in = 1'b0; push(cyc + 6, 1, 0, 1, 1);
      waitN(10);
      @(negedge clk); button_in = 1'b1; push(cyc + 6, 0, 1, 0, 0);
      waitN(10);

      // release bounce while held
      @(negedge clk); button_in = 1'b0; push(cyc + 6, 1, 0, 1, 1);
      waitN(10);
      @(negedge clk); button_in = 1'b1;
      @(negedge clk);
      @(negedge clk); button_in = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("relbounce_pressed", pressed, 1'b1);
      end
      @(negedge clk); button_in = 1'b1; push(cyc + 6, 0, 1, 0, 0);
      waitN(10);

      // auto-repeat, then drop repeat_en
      @(negedge clk); repeat_en = 1'b1; button_in = 1'b0; base = cyc;
      push(base + 6, 1, 0, 1, 1);
      push(base + 16, 0, 0, 1, 1);
      push(base + 19, 0, 0, 1, 1);
      push(base + 22, 0, 0, 1, 1);
      push(base + 25, 0, 0, 1, 1);
      push(base + 28, 0, 0, 1, 1);
      waitN(29);
      repeat_en = 1'b0;
      waitN(15);
      chk("repeat_off_pressed", pressed, 1'b1);
      @(negedge clk); button_in = 1'b1; push(cyc + 6, 0, 1, 0, 0);
      waitN(10);

      // release coinciding with a due strobe: release wins
      @(negedge clk); repeat_en = 1'b1; button_in = 1'b0; base = cyc;
      push(base + 6, 1, 0, 1, 1);
      push(base + 16, 0, 0, 1, 1);
      push(base + 19, 0, 0, 1, 1);
      waitN(19);
      button_in = 1'b1; push(base + 25, 0, 1, 0, 0);
      waitN(10);
      repeat_en = 1'b0;

      // asynchronous reset mid-held, released with key still down
      @(negedge clk); button_in = 1'b0; push(cyc + 6, 1, 0, 1, 1);
      waitN(9);
      chk("prereset_pressed", pressed, 1'b1);
      reset = 1'b0;
      #1 chkOutsLow("async_reset");
      waitN(3);
      reset = 1'b1; push(cyc + 6, 1, 0, 1, 1);
      waitN(10);
      @(negedge clk); button_in = 1'b1; push(cyc + 6, 0, 1, 0, 0);
      waitN(12);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL missing_events got pending=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got cycle=%0d required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
